// File: rtl/jt10_adpcmb_romfetch_if.sv
// Word-wide memory bus between the ADPCM-B fetch front end and external memory.
//   mem_addr  23  word address (driven by master)
//   mem_req    1  level request, held until acknowledged (driven by master)
//   mem_ack    1  one-cycle acknowledge, mem_dout valid in that cycle (driven by slave)
//   mem_dout  16  word read from memory (driven by slave)
interface jt10_adpcmb_romfetch_if;
    logic [22:0] mem_addr;
    logic        mem_req;
    logic        mem_ack;
    logic [15:0] mem_dout;

    modport master (output mem_addr, output mem_req, input mem_ack, input mem_dout);
    modport slave  (input mem_addr, input mem_req, output mem_ack, output mem_dout);
endinterface

// File: rtl/jt10_adpcmb_romfetch.sv
// ADPCM-B ROM fetch front end.
// Serves bytes to the ADPCM-B driver from a two-slot word buffer: CUR holds the
// word being read, NXT holds the prefetched following word. Buffer fills go out on
// a 16-bit req/ack memory bus with at most one transaction in flight.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clr          synchronous invalidate of both slots (ROM reload)
//   roe_n        one-cycle active-low read strobe from the driver
//   addr  [23:0] byte address, valid while roe_n is low
//   data  [7:0]  registered byte to the driver, held between updates
//   late         one-cycle pulse when a strobe lands on a still-pending demand fill
//   mem          memory bus (master side)
module jt10_adpcmb_romfetch #(
    parameter int BSWAP    = 0,
    parameter int PREFETCH = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clr,
    input  logic                          roe_n,
    input  logic [23:0]                   addr,
    output logic [7:0]                    data,
    output logic                          late,
    jt10_adpcmb_romfetch_if.master        mem
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DEMAND = 2'd1,
        ST_PREF   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        cur_v_q, cur_v_d;
    logic [22:0] cur_tag_q, cur_tag_d;
    logic [15:0] cur_word_q, cur_word_d;
    logic        nxt_v_q, nxt_v_d;
    logic [22:0] nxt_tag_q, nxt_tag_d;
    logic [15:0] nxt_word_q, nxt_word_d;
    logic        pend_v_q, pend_v_d;
    logic [22:0] pend_tag_q, pend_tag_d;
    logic        pend_b_q, pend_b_d;
    logic        disc_q, disc_d;      // outstanding transaction was orphaned by clr
    logic [22:0] mem_addr_q, mem_addr_d;
    logic        mem_req_q, mem_req_d;
    logic [7:0]  data_q, data_d;
    logic        late_q, late_d;

    logic        strobe_s;
    logic [22:0] wtag_s;
    logic        ack_s;
    logic        demand_fill_s;
    logic        pref_fill_s;
    logic        pf_want_s;
    logic [22:0] pf_tag_s;

    // Byte lane select inside a 16-bit word, honouring the byte order option.
    function automatic logic [7:0] sel_byte(input logic [15:0] w, input logic b);
        logic hi;
        hi = b ^ (BSWAP != 0);
        return hi ? w[15:8] : w[7:0];
    endfunction

    assign strobe_s = ~roe_n;
    assign wtag_s   = addr[23:1];
    // Acks without an outstanding request are ignored.
    assign ack_s    = mem.mem_ack & mem_req_q;

    // A demand ack only fills CUR if it still answers the latest pending miss.
    assign demand_fill_s = ack_s && (state_q == ST_DEMAND) && !disc_q && pend_v_q
                           && (mem_addr_q == pend_tag_q);
    // A prefetch ack is only useful if it still follows CUR and no miss overtook it.
    assign pref_fill_s   = ack_s && (state_q == ST_PREF) && !disc_q && cur_v_q
                           && !pend_v_q && (mem_addr_q == (cur_tag_q + 23'd1));

    // Next-state: ack write first, then clr, then strobe lookup, then bus sequencing.
    always_comb begin
        state_d    = state_q;
        cur_v_d    = cur_v_q;
        cur_tag_d  = cur_tag_q;
        cur_word_d = cur_word_q;
        nxt_v_d    = nxt_v_q;
        nxt_tag_d  = nxt_tag_q;
        nxt_word_d = nxt_word_q;
        pend_v_d   = pend_v_q;
        pend_tag_d = pend_tag_q;
        pend_b_d   = pend_b_q;
        disc_d     = disc_q;
        mem_addr_d = mem_addr_q;
        mem_req_d  = mem_req_q;
        data_d     = data_q;
        late_d     = 1'b0;
        pf_want_s  = 1'b0;
        pf_tag_s   = 23'd0;

        if (demand_fill_s) begin
            cur_v_d    = 1'b1;
            cur_tag_d  = mem_addr_q;
            cur_word_d = mem.mem_dout;
            data_d     = sel_byte(mem.mem_dout, pend_b_q);
            pend_v_d   = 1'b0;
            pf_want_s  = (PREFETCH != 0);
            pf_tag_s   = mem_addr_q + 23'd1;
        end else if (pref_fill_s) begin
            nxt_v_d    = 1'b1;
            nxt_tag_d  = mem_addr_q;
            nxt_word_d = mem.mem_dout;
        end else begin
            // stale or discarded acks leave the slots untouched
            nxt_v_d    = nxt_v_d;
        end

        if (clr) begin
            cur_v_d   = 1'b0;
            nxt_v_d   = 1'b0;
            pend_v_d  = 1'b0;
            pf_want_s = 1'b0;
        end else begin
            cur_v_d   = cur_v_d;
        end

        if (strobe_s) begin
            if (!clr && cur_v_d && (cur_tag_d == wtag_s)) begin
                data_d = sel_byte(cur_word_d, addr[0]);
            end else if (!clr && nxt_v_d && (nxt_tag_d == wtag_s)) begin
                cur_v_d    = 1'b1;
                cur_tag_d  = nxt_tag_d;
                cur_word_d = nxt_word_d;
                nxt_v_d    = 1'b0;
                data_d     = sel_byte(nxt_word_d, addr[0]);
                pf_want_s  = (PREFETCH != 0);
                pf_tag_s   = wtag_s + 23'd1;
            end else begin
                cur_v_d    = 1'b0;
                nxt_v_d    = 1'b0;
                pend_v_d   = 1'b1;
                pend_tag_d = wtag_s;
                pend_b_d   = addr[0];
                pf_want_s  = 1'b0;
                // the demand fill is still outstanding after this cycle
                late_d     = (state_q == ST_DEMAND) && !demand_fill_s;
            end
        end else begin
            late_d = 1'b0;
        end

        // The bus may only move when idle or on the ack cycle.
        if ((state_q == ST_IDLE) || ack_s) begin
            disc_d = 1'b0;
            if (pend_v_d) begin
                state_d    = ST_DEMAND;
                mem_req_d  = 1'b1;
                mem_addr_d = pend_tag_d;
            end else if (pf_want_s) begin
                state_d    = ST_PREF;
                mem_req_d  = 1'b1;
                mem_addr_d = pf_tag_s;
            end else begin
                state_d    = ST_IDLE;
                mem_req_d  = 1'b0;
            end
        end else begin
            disc_d = disc_q | clr;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cur_v_q    <= 1'b0;
            cur_tag_q  <= 23'd0;
            cur_word_q <= 16'd0;
            nxt_v_q    <= 1'b0;
            nxt_tag_q  <= 23'd0;
            nxt_word_q <= 16'd0;
            pend_v_q   <= 1'b0;
            pend_tag_q <= 23'd0;
            pend_b_q   <= 1'b0;
            disc_q     <= 1'b0;
            mem_addr_q <= 23'd0;
            mem_req_q  <= 1'b0;
            data_q     <= 8'd0;
            late_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_v_q    <= cur_v_d;
            cur_tag_q  <= cur_tag_d;
            cur_word_q <= cur_word_d;
            nxt_v_q    <= nxt_v_d;
            nxt_tag_q  <= nxt_tag_d;
            nxt_word_q <= nxt_word_d;
            pend_v_q   <= pend_v_d;
            pend_tag_q <= pend_tag_d;
            pend_b_q   <= pend_b_d;
            disc_q     <= disc_d;
            mem_addr_q <= mem_addr_d;
            mem_req_q  <= mem_req_d;
            data_q     <= data_d;
            late_q     <= late_d;
        end
    end

    assign data         = data_q;
    assign late         = late_q;
    assign mem.mem_addr = mem_addr_q;
    assign mem.mem_req  = mem_req_q;

endmodule

// File: tb/tb_jt10_adpcmb_romfetch.sv
module tb_jt10_adpcmb_romfetch;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        roe_n;
    logic [23:0] addr;
    logic [7:0]  data;
    logic        late;
    int          total;
    int          bad;

    jt10_adpcmb_romfetch_if mem_if ();

    jt10_adpcmb_romfetch #(.BSWAP(0), .PREFETCH(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .roe_n (roe_n),
        .addr  (addr),
        .data  (data),
        .late  (late),
        .mem   (mem_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [23:0] a);
        roe_n = 1'b0;
        addr  = a;
        tick();
        roe_n = 1'b1;
    endtask

    task automatic ack(input logic [15:0] w);
        mem_if.mem_ack  = 1'b1;
        mem_if.mem_dout = w;
        tick();
        mem_if.mem_ack  = 1'b0;
        mem_if.mem_dout = 16'h0000;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0; roe_n = 1'b1; addr = 24'd0;
        mem_if.mem_ack = 1'b0; mem_if.mem_dout = 16'h0000;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        total++; if (data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", data); end
        total++; if (mem_if.mem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", mem_if.mem_req); end
        total++; if (mem_if.mem_addr !== 23'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", mem_if.mem_addr); end
        total++; if (late !== 1'b0) begin bad++; $display("FAIL reset_late got=%b exp=0", late); end
    endtask

    task automatic test_cold_miss();
        strobe(24'h000100);
        total++; if (mem_if.mem_req !== 1'b1) begin bad++; $display("FAIL cold_req got=%b exp=1", mem_if.mem_req); end
        total++; if (mem_if.mem_addr !== 23'h000080) begin bad++; $display("FAIL cold_addr got=%h exp=000080", mem_if.mem_addr); end
        tick(); tick(); tick(); tick();
        total++; if (data !== 8'h00) begin bad++; $display("FAIL cold_hold got=%h exp=00", data); end
        ack(16'hA1B2);
        total++; if (data !== 8'hB2) begin bad++; $display("FAIL cold_data got=%h exp=B2", data); end
        total++; if (mem_if.mem_addr !== 23'h000081) begin bad++; $display("FAIL cold_pref_addr got=%h exp=000081", mem_if.mem_addr); end
        total++; if (mem_if.mem_req !== 1'b1) begin bad++; $display("FAIL cold_pref_req got=%b exp=1", mem_if.mem_req); end
        tick();
        ack(16'hC3D4);
        total++; if (mem_if.mem_req !== 1'b0) begin bad++; $display("FAIL cold_idle got=%b exp=0", mem_if.mem_req); end
    endtask

    task automatic test_sequential();
        strobe(24'h000101);
        total++; if (data !== 8'hA1) begin bad++; $display("FAIL seq_hit_data got=%h exp=A1", data); end
        total++; if (mem_if.mem_req !== 1'b0) begin bad++; $display("FAIL seq_hit_req got=%b exp=0", mem_if.mem_req); end
        strobe(24'h000102);
        total++; if (data !== 8'hD4) begin bad++; $display("FAIL seq_next_data got=%h exp=D4", data); end
        total++; if (mem_if.mem_req !== 1'b1) begin bad++; $display("FAIL seq_pref_req got=%b exp=1", mem_if.mem_req); end
        total++; if (mem_if.mem_addr !== 23'h000082) begin bad++; $display("FAIL seq_pref_addr got=%h exp=000082", mem_if.mem_addr); end
        strobe(24'h000103);
        total++; if (data !== 8'hC3) begin bad++; $display("FAIL seq_hit2_data got=%h exp=C3", data); end
    endtask

    task automatic test_jump_and_late();
        strobe(24'h200000);
        total++; if (late !== 1'b0) begin bad++; $display("FAIL jump_late got=%b exp=0", late); end
        total++; if (mem_if.mem_addr !== 23'h000082) begin bad++; $display("FAIL jump_hold_addr got=%h exp=000082", mem_if.mem_addr); end
        tick(); tick();
        ack(16'h5555);
        total++; if (mem_if.mem_addr !== 23'h100000) begin bad++; $display("FAIL jump_dem_addr got=%h exp=100000", mem_if.mem_addr); end
        total++; if (mem_if.mem_req !== 1'b1) begin bad++; $display("FAIL jump_dem_req got=%b exp=1", mem_if.mem_req); end
        total++; if (data !== 8'hC3) begin bad++; $display("FAIL jump_data_hold got=%h exp=C3", data); end
        strobe(24'h300011);
        total++; if (late !== 1'b1) begin bad++; $display("FAIL late_pulse got=%b exp=1", late); end
        tick();
        total++; if (late !== 1'b0) begin bad++; $display("FAIL late_once got=%b exp=0", late); end
        ack(16'hDEAD);
        total++; if (data !== 8'hC3) begin bad++; $display("FAIL late_stale_data got=%h exp=C3", data); end
        total++; if (mem_if.mem_addr !== 23'h180008) begin bad++; $display("FAIL late_reissue got=%h exp=180008", mem_if.mem_addr); end
        ack(16'hBEEF);
        total++; if (data !== 8'hBE) begin bad++; $display("FAIL late_fill_data got=%h exp=BE", data); end
        total++; if (mem_if.mem_addr !== 23'h180009) begin bad++; $display("FAIL late_pref got=%h exp=180009", mem_if.mem_addr); end
        ack(16'h0000);
    endtask

    task automatic test_wrap();
        strobe(24'hFFFFFE);
        total++; if (mem_if.mem_addr !== 23'h7FFFFF) begin bad++; $display("FAIL wrap_dem got=%h exp=7FFFFF", mem_if.mem_addr); end
        ack(16'h9A78);
        total++; if (data !== 8'h78) begin bad++; $display("FAIL wrap_data got=%h exp=78", data); end
        total++; if (mem_if.mem_addr !== 23'h000000) begin bad++; $display("FAIL wrap_pref got=%h exp=000000", mem_if.mem_addr); end
        ack(16'h3412);
        strobe(24'h000001);
        total++; if (data !== 8'h34) begin bad++; $display("FAIL wrap_next_data got=%h exp=34", data); end
        total++; if (mem_if.mem_addr !== 23'h000001) begin bad++; $display("FAIL wrap_next_pref got=%h exp=000001", mem_if.mem_addr); end
        ack(16'h7788);
        total++; if (mem_if.mem_req !== 1'b0) begin bad++; $display("FAIL wrap_idle got=%b exp=0", mem_if.mem_req); end
    endtask

    task automatic test_stray_ack();
        ack(16'hFFFF);
        total++; if (data !== 8'h34) begin bad++; $display("FAIL stray_data got=%h exp=34", data); end
        total++; if (mem_if.mem_req !== 1'b0) begin bad++; $display("FAIL stray_req got=%b exp=0", mem_if.mem_req); end
    endtask

    task automatic test_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        total++; if (data !== 8'h34) begin bad++; $display("FAIL clr_data got=%h exp=34", data); end
        strobe(24'h000000);
        total++; if (mem_if.mem_req !== 1'b1) begin bad++; $display("FAIL clr_miss_req got=%b exp=1", mem_if.mem_req); end
        total++; if (mem_if.mem_addr !== 23'h000000) begin bad++; $display("FAIL clr_miss_addr got=%h exp=000000", mem_if.mem_addr); end
        ack(16'h6655);
        total++; if (data !== 8'h55) begin bad++; $display("FAIL clr_fill got=%h exp=55", data); end
        ack(16'h0102);
        // clr together with a strobe to a buffered word must still miss
        clr = 1'b1;
        strobe(24'h000001);
        clr = 1'b0;
        total++; if (mem_if.mem_addr !== 23'h000000 || mem_if.mem_req !== 1'b1) begin bad++; $display("FAIL clr_strobe_req got=%b/%h exp=1/000000", mem_if.mem_req, mem_if.mem_addr); end
        total++; if (data !== 8'h55) begin bad++; $display("FAIL clr_strobe_hold got=%h exp=55", data); end
        ack(16'h1100);
        total++; if (data !== 8'h11) begin bad++; $display("FAIL clr_strobe_fill got=%h exp=11", data); end
        ack(16'h0000);
    endtask

    task automatic test_reset_mid();
        strobe(24'h000400);
        total++; if (mem_if.mem_addr !== 23'h000200) begin bad++; $display("FAIL rmid_dem got=%h exp=000200", mem_if.mem_addr); end
        rst_n = 1'b0;
        #2;
        total++; if (mem_if.mem_req !== 1'b0) begin bad++; $display("FAIL rmid_req got=%b exp=0", mem_if.mem_req); end
        total++; if (data !== 8'h00) begin bad++; $display("FAIL rmid_data got=%h exp=00", data); end
        total++; if (mem_if.mem_addr !== 23'h0) begin bad++; $display("FAIL rmid_addr got=%h exp=0", mem_if.mem_addr); end
        tick();
        rst_n = 1'b1;
        tick();
        strobe(24'h000400);
        total++; if (mem_if.mem_req !== 1'b1 || mem_if.mem_addr !== 23'h000200) begin bad++; $display("FAIL rmid_miss got=%b/%h exp=1/000200", mem_if.mem_req, mem_if.mem_addr); end
        total++; if (data !== 8'h00) begin bad++; $display("FAIL rmid_nohit got=%h exp=00", data); end
        ack(16'h2211);
        total++; if (data !== 8'h11) begin bad++; $display("FAIL rmid_fill got=%h exp=11", data); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_cold_miss();
        test_sequential();
        test_jump_and_late();
        test_wrap();
        test_stray_ack();
        test_clr();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
